// File: rtl/display_scan.sv
// display_scan: time-multiplexed scanner for an eight-digit seven-segment
// display. It holds a 32-bit display value and selects one digit per slot of
// DIV clock cycles. For that digit it drives the hex nibble to the segment
// decoder and pulls the matching active-low anode. The anodes stay dark on the
// first cycle of every slot so the previous digit's segments do not ghost.
module display_scan #(
    parameter int unsigned DIV = 100000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] data_in,
    input  logic        load,
    input  logic [7:0]  blank_mask,
    output logic [3:0]  code,
    output logic [7:0]  an,
    output logic [2:0]  sel,
    output logic        frame
);

    // Prescaler width; DIV is at least 2, so this is always at least 1 bit.
    localparam int unsigned    CNT_W    = $clog2(DIV);
    localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(DIV - 32'd1);
    localparam logic [CNT_W-1:0] CNT_ZERO = CNT_W'(0);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [2:0]     IDX_LAST = 3'd7;
    localparam logic [7:0]     AN_OFF   = 8'hFF;

    // Scan state: prescaler, digit index, and the latched display value.
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    logic [2:0]       idx_q;
    logic [2:0]       idx_d;
    logic [31:0]      disp_q;
    logic [31:0]      disp_d;

    // Decoded slot-position flags shared by next-state and output logic.
    logic slot_wrap_s;
    logic slot_gap_s;
    logic digit_blank_s;
    logic [7:0] an_onehot_s;

    assign slot_wrap_s = (cnt_q == CNT_MAX);
    assign slot_gap_s  = (cnt_q == CNT_ZERO);

    // Next-state logic: prescaler wrap advances the digit; load captures data.
    always_comb begin
        cnt_d  = cnt_q;
        idx_d  = idx_q;
        disp_d = disp_q;

        if (load) begin
            disp_d = data_in;
        end else begin
            disp_d = disp_q;
        end

        if (slot_wrap_s) begin
            cnt_d = CNT_ZERO;
            idx_d = idx_q + 3'd1;
        end else begin
            cnt_d = cnt_q + CNT_ONE;
            idx_d = idx_q;
        end
    end

    // State registers with synchronous reset; reset aborts the scan to digit 0.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q  <= CNT_ZERO;
            idx_q  <= 3'd0;
            disp_q <= 32'h0000_0000;
        end else begin
            cnt_q  <= cnt_d;
            idx_q  <= idx_d;
            disp_q <= disp_d;
        end
    end

    // Nibble select for the current digit; digit 0 is the least significant.
    always_comb begin
        code = 4'h0;
        case (idx_q)
            3'd0:    code = disp_q[3:0];
            3'd1:    code = disp_q[7:4];
            3'd2:    code = disp_q[11:8];
            3'd3:    code = disp_q[15:12];
            3'd4:    code = disp_q[19:16];
            3'd5:    code = disp_q[23:20];
            3'd6:    code = disp_q[27:24];
            3'd7:    code = disp_q[31:28];
            default: code = 4'h0;
        endcase
    end

    // One-hot anode pattern for the current digit before inversion.
    always_comb begin
        an_onehot_s = 8'h00;
        case (idx_q)
            3'd0:    an_onehot_s = 8'b0000_0001;
            3'd1:    an_onehot_s = 8'b0000_0010;
            3'd2:    an_onehot_s = 8'b0000_0100;
            3'd3:    an_onehot_s = 8'b0000_1000;
            3'd4:    an_onehot_s = 8'b0001_0000;
            3'd5:    an_onehot_s = 8'b0010_0000;
            3'd6:    an_onehot_s = 8'b0100_0000;
            3'd7:    an_onehot_s = 8'b1000_0000;
            default: an_onehot_s = 8'h00;
        endcase
    end

    // Per-digit blanking; the mask is live so changes apply within the slot.
    always_comb begin
        digit_blank_s = 1'b0;
        case (idx_q)
            3'd0:    digit_blank_s = blank_mask[0];
            3'd1:    digit_blank_s = blank_mask[1];
            3'd2:    digit_blank_s = blank_mask[2];
            3'd3:    digit_blank_s = blank_mask[3];
            3'd4:    digit_blank_s = blank_mask[4];
            3'd5:    digit_blank_s = blank_mask[5];
            3'd6:    digit_blank_s = blank_mask[6];
            3'd7:    digit_blank_s = blank_mask[7];
            default: digit_blank_s = 1'b0;
        endcase
    end

    // Anode drive: dark on the gap cycle or for masked digits, else one low bit.
    always_comb begin
        an = AN_OFF;
        if (slot_gap_s || digit_blank_s) begin
            an = AN_OFF;
        end else begin
            an = ~an_onehot_s;
        end
    end

    // Digit index and end-of-frame marker on the last cycle of digit 7.
    always_comb begin
        sel   = idx_q;
        frame = 1'b0;
        if ((idx_q == IDX_LAST) && slot_wrap_s) begin
            frame = 1'b1;
        end else begin
            frame = 1'b0;
        end
    end

endmodule
